// File: rtl/box_pkg.sv
// Shared definitions for the box plotter: screen geometry, colours,
// FSM state encoding and the box request record.
package box_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int BOX_W_DEF = 3;
    localparam int BOX_H_DEF = 3;

    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } box_req_t;

    // True when an unclipped pixel coordinate lies on the visible screen.
    function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy,
                                       input int xmax, input int ymax);
        return (int'(sx) <= xmax) && (int'(sy) <= ymax);
    endfunction

endpackage

// File: rtl/box_plotter_if.sv
// Box request channel between a box-colouring producer and the plotter.
//
// Handshake: a request is transferred on every rising clock edge where
// req_valid and req_ready are both high. While req_valid is high and
// req_ready is low the producer holds req_x/req_y/req_colour stable and
// keeps req_valid high; req_ready never depends combinationally on
// req_valid.
interface box_req_if;

    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;

    modport master (
        output req_valid,
        output req_x,
        output req_y,
        output req_colour,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_x,
        input  req_y,
        input  req_colour,
        output req_ready
    );

endinterface

// File: rtl/box_req_fifo.sv
// Small synchronous FIFO of box requests. Full and empty come straight
// from the occupancy register, so a pop in the same cycle never opens a
// combinational path back to the push side.
module box_req_fifo
    import box_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  box_req_t data_i,
    input  logic     pop_i,
    output box_req_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);

    box_req_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage array: written on accepted pushes only, contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/box_plotter.sv
// Expands queued (x, y, colour) box origins into a BOX_W x BOX_H run of
// single-pixel writes for the VGA adapter, row-major from the top-left.
// All adapter-facing outputs are registered and describe the slot being
// presented in the current cycle.
module box_plotter
    import box_pkg::*;
#(
    parameter int BOX_W      = BOX_W_DEF,
    parameter int BOX_H      = BOX_H_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int X_MAX      = SCREEN_W - 1,
    parameter int Y_MAX      = SCREEN_H - 1
) (
    input  logic        clk,
    input  logic        resetn,
    box_req_if.slave    req,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot,
    output logic        busy,
    output logic        box_done,
    output state_t      state_dbg
);

    localparam logic [2:0] CX_LAST = 3'(BOX_W - 1);
    localparam logic [2:0] CY_LAST = 3'(BOX_H - 1);

    state_t     state_q, state_d;
    logic [2:0] cx_q, cx_d;
    logic [2:0] cy_q, cy_d;
    box_req_t   base_q, base_d;

    box_req_t   push_data;
    box_req_t   fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       last_slot;

    logic [8:0] sum_x;
    logic [7:0] sum_y;

    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_col_q, vga_col_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    assign push_data     = '{x: req.req_x, y: req.req_y, colour: req.req_colour};
    assign req.req_ready = !fifo_full;
    assign last_slot     = (cx_q == CX_LAST) && (cy_q == CY_LAST);

    box_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (req.req_valid),
        .data_i  (push_data),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // FSM state, slot counters and the latched box origin/colour.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            base_q  <= base_d;
        end
    end

    // Next state: pop a box when idle, walk its slots, chain straight into the next box.
    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        base_d   = base_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    base_d   = fifo_head;
                    cx_d     = '0;
                    cy_d     = '0;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (last_slot) begin
                    cx_d = '0;
                    cy_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        base_d   = fifo_head;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cx_q == CX_LAST) begin
                    cx_d = '0;
                    cy_d = cy_q + 3'd1;
                end else begin
                    cx_d = cx_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the slot presented next cycle, clipped against the screen.
    always_comb begin
        sum_x     = {1'b0, base_d.x} + {6'b0, cx_d};
        sum_y     = {1'b0, base_d.y} + {5'b0, cy_d};
        vga_x_d   = sum_x[7:0];
        vga_y_d   = sum_y[6:0];
        vga_col_d = base_d.colour;
        plot_d    = (state_d == DRAW) && on_screen(sum_x, sum_y, X_MAX, Y_MAX);
        done_d    = (state_q == DRAW) && last_slot;
        busy_d    = !fifo_empty || (state_q == DRAW);
    end

    // Registered adapter outputs and status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            vga_col_q <= vga_col_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign box_done   = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_box_plotter.sv
// Bench for box_plotter: randomized and directed box requests checked
// against a pixel-list model built from box geometry and screen clipping.
`timescale 1ns/1ps
module tb_box_plotter;
    import box_pkg::*;

    localparam int BW = 3;
    localparam int BH = 3;
    localparam int XM = 159;
    localparam int YM = 119;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       box_done;
    state_t     state_dbg;

    box_req_if rif ();

    box_plotter #(
        .BOX_W      (BW),
        .BOX_H      (BH),
        .FIFO_DEPTH (4),
        .X_MAX      (XM),
        .Y_MAX      (YM)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (rif),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .box_done   (box_done),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard state.
    int          n_checks = 0;
    int          n_err = 0;
    logic [17:0] exp_q[$];
    int          done_q[$];
    int          plot_cnt = 0;
    int          gap_cnt = 0;
    int          first_plot_cyc = 0;
    int          last_plot_cyc = 0;
    int          exp_plot_total = 0;
    logic [17:0] e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: every on-screen pixel of a box, in row-major order.
    task automatic model_push(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        for (int r = 0; r < BH; r++) begin
            for (int k = 0; k < BW; k++) begin
                int sx;
                int sy;
                sx = int'(x) + k;
                sy = int'(y) + r;
                if (sx <= XM && sy <= YM) begin
                    exp_q.push_back({8'(sx), 7'(sy), c});
                    exp_plot_total++;
                end
            end
        end
    endtask

    // Monitor: plotted pixels against the model, timing of plots and done pulses.
    always @(negedge clk) begin
        if (resetn) begin
            if (plot) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_plot", {14'd0, vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, e});
                end
                if (plot_cnt == 0) first_plot_cyc = cyc;
                else if (last_plot_cyc != cyc - 1) gap_cnt++;
                last_plot_cyc = cyc;
                plot_cnt++;
            end
            if (box_done) done_q.push_back(cyc);
        end
    end

    // Driver tasks.
    task automatic send_now(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                            input bit wiggle, output int acc, output bit stalled);
        int waited;
        waited = 0;
        stalled = 1'b0;
        rif.req_valid  = 1'b1;
        rif.req_x      = x;
        rif.req_y      = y;
        rif.req_colour = c;
        while (!rif.req_ready && waited < 200) begin
            stalled = 1'b1;
            if (wiggle) begin
                rif.req_x      = 8'($urandom);
                rif.req_y      = 7'($urandom);
                rif.req_colour = 3'($urandom);
            end
            @(negedge clk);
            waited++;
        end
        if (!rif.req_ready) check("accept_timeout", 32'(rif.req_ready), 1);
        rif.req_x      = x;
        rif.req_y      = y;
        rif.req_colour = c;
        model_push(x, y, c);
        acc = cyc;
    endtask

    task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                        input bit wiggle, output int acc, output bit stalled);
        @(negedge clk);
        send_now(x, y, c, wiggle, acc, stalled);
    endtask

    task automatic idle_req();
        @(negedge clk);
        rif.req_valid = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_stats();
        plot_cnt = 0;
        gap_cnt = 0;
        exp_plot_total = 0;
        done_q.delete();
    endtask

    // Stimulus.
    initial begin
        int  acc, n0, n1, snap, gap, n;
        bit  st, any_stall;
        logic [7:0] rx;
        logic [6:0] ry;

        rif.req_valid  = 1'b0;
        rif.req_x      = '0;
        rif.req_y      = '0;
        rif.req_colour = '0;

        // Reset values.
        #1;
        check("rst_plot", 32'(plot), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(box_done), 0);
        check("rst_vga", {14'd0, vga_x, vga_y, vga_colour}, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_ready", 32'(rif.req_ready), 1);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // Single white box: latency, order, done pulse, busy.
        clear_stats();
        send(8'd38, 7'd3, WHITE, 1'b0, acc, st);
        idle_req();
        wait_until(acc + 5);
        check("t1_busy_mid", 32'(busy), 1);
        wait_idle();
        check("t1_plots", plot_cnt, 9);
        check("t1_first", first_plot_cyc, acc + 2);
        check("t1_last", last_plot_cyc, acc + 10);
        check("t1_gaps", gap_cnt, 0);
        check("t1_done_n", done_q.size(), 1);
        if (done_q.size() >= 1) check("t1_done_cyc", done_q[0], acc + 11);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_left", exp_q.size(), 0);

        // Back-to-back requests overflowing the FIFO; last one wiggles while stalled.
        clear_stats();
        any_stall = 1'b0;
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            send(8'(10 + 20 * i), 7'(10 + 5 * i), 3'(i + 1), (i == 5), acc, st);
            if (i == 0) n0 = acc;
            if (i < 5) any_stall = any_stall | st;
            else check("t2_stall6", 32'(st), 1);
        end
        idle_req();
        wait_idle();
        check("t2_no_early_stall", 32'(any_stall), 0);
        check("t2_plots", plot_cnt, 54);
        check("t2_gaps", gap_cnt, 0);
        check("t2_first", first_plot_cyc, n0 + 2);
        check("t2_done_n", done_q.size(), 6);
        for (int k = 0; k < done_q.size() && k < 6; k++) begin
            check("t2_done_cyc", done_q[k], n0 + 11 + 9 * k);
        end
        check("t2_left", exp_q.size(), 0);

        // Clipping at the bottom-right corner and a fully off-screen box.
        clear_stats();
        send(8'd158, 7'd118, 3'b010, 1'b0, acc, st);
        idle_req();
        wait_idle();
        check("t3_plots", plot_cnt, 4);
        check("t3_first", first_plot_cyc, acc + 2);
        check("t3_last", last_plot_cyc, acc + 6);
        check("t3_done_n", done_q.size(), 1);
        if (done_q.size() >= 1) check("t3_done_cyc", done_q[0], acc + 11);
        clear_stats();
        send(8'd200, 7'd50, 3'b101, 1'b0, acc, st);
        idle_req();
        wait_idle();
        check("t3_off_plots", plot_cnt, 0);
        check("t3_off_done_n", done_q.size(), 1);
        if (done_q.size() >= 1) check("t3_off_done_cyc", done_q[0], acc + 11);

        // Chained box: push lands on the last pixel of the running box with one queued.
        clear_stats();
        send(8'd50, 7'd60, 3'd1, 1'b0, n1, st);
        idle_req();
        wait_until(n1 + 3);
        send_now(8'd53, 7'd60, 3'd2, 1'b0, acc, st);
        idle_req();
        wait_until(n1 + 10);
        send_now(8'd56, 7'd60, 3'd6, 1'b0, acc, st);
        check("t6_ready_last", 32'(st), 0);
        idle_req();
        wait_idle();
        check("t6_plots", plot_cnt, 27);
        check("t6_gaps", gap_cnt, 0);
        check("t6_done_n", done_q.size(), 3);
        for (int k = 0; k < done_q.size() && k < 3; k++) begin
            check("t6_done_cyc", done_q[k], n1 + 11 + 9 * k);
        end
        check("t6_left", exp_q.size(), 0);

        // Reset during the 4th pixel with two requests queued.
        clear_stats();
        send(8'd20, 7'd20, 3'd3, 1'b0, acc, st);
        send(8'd30, 7'd30, 3'd4, 1'b0, acc, st);
        send(8'd40, 7'd40, 3'd5, 1'b0, acc, st);
        idle_req();
        n = 0;
        while (plot_cnt < 4 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("t4_reach4", plot_cnt, 4);
        resetn = 1'b0;
        #1;
        check("t4_plot_async", 32'(plot), 0);
        check("t4_busy_async", 32'(busy), 0);
        check("t4_done_async", 32'(box_done), 0);
        exp_q.delete();
        snap = done_q.size();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("t4_ready", 32'(rif.req_ready), 1);
        repeat (20) @(negedge clk);
        #1;
        check("t4_busy", 32'(busy), 0);
        check("t4_plots", plot_cnt, 4);
        check("t4_done_n", done_q.size(), snap);

        // Random traffic, including off-screen origins and stalled data changes.
        clear_stats();
        for (int i = 0; i < 25; i++) begin
            rx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 157));
            ry = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 117));
            send(rx, ry, 3'($urandom), 1'($urandom), acc, st);
            gap = $urandom_range(0, 12);
            if (gap != 0) begin
                idle_req();
                repeat (gap - 1) @(negedge clk);
            end
        end
        idle_req();
        wait_idle();
        check("rnd_plots", plot_cnt, exp_plot_total);
        check("rnd_done_n", done_q.size(), 25);
        check("rnd_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
